intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter GREEN_T, default 6: full green phase length in ticks.
REQ-002 Parameter AMBER_T, default 2: amber phase length in ticks.
REQ-003 Parameter CLEAR_T, default 1: all-red clearance length in ticks.
REQ-004 Parameter WALK_T, default 4: pedestrian walk length in ticks.
REQ-005 Parameter MIN_GREEN_T, default 3: minimum green length in ticks before a pedestrian request may cut green short.
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 rst_i  input  1  reset, synchronous, active-high.
REQ-008 tick_i  input  1  timebase enable; timers advance only on cycles with tick_i=1.
REQ-009 ped_req_i  input  1  pedestrian button, level or pulse, sampled every clk_i edge.
REQ-010 ns_green_o, ns_amber_o, ns_red_o  output  1 each  north-south lamps.
REQ-011 ew_green_o, ew_amber_o, ew_red_o  output  1 each  east-west lamps.
REQ-012 walk_o  output  1  pedestrian walk lamp.
REQ-013 ped_wait_o  output  1  pedestrian request latched, not yet served.
REQ-014 state_o  output  3  current phase encoding.
REQ-015 time_o  output  5  ticks remaining in current phase, minus one.

Function
REQ-016 Phases, with encodings: NS_G=0, NS_A=1, CLR_A=2, EW_G=3, EW_A=4, CLR_B=5, WALK=6; code 7 is illegal and recovers to NS_G with time_o=GREEN_T-1 on the next edge.
REQ-017 On phase entry, time_o loads that phase's duration minus 1; each tick_i=1 cycle with time_o>0 decrements it.
REQ-018 Every phase exits on a tick_i=1 cycle with time_o=0; without tick_i, state and time_o hold.
REQ-019 Normal sequence: NS_G->NS_A->CLR_A->EW_G->EW_A->CLR_B->NS_G; one 18-tick cycle at defaults.
REQ-020 ped_pending sets on any cycle with ped_req_i=1 and state!=WALK; it clears on the edge entering WALK, and clear wins over a simultaneous set; ped_wait_o=ped_pending.
REQ-021 Early green end: in NS_G/EW_G, if ped_pending=1, tick_i=1 and time_o<=GREEN_T-MIN_GREEN_T, the phase exits to its amber.
REQ-022 On exit from CLR_A or CLR_B with ped_pending=1, the next phase is WALK instead of the next green.
REQ-023 WALK exits to EW_G if entered from CLR_A, and to NS_G if entered from CLR_B; a 1-bit next-direction register records which.
REQ-024 Lamps are decoded from the state register only (Moore), with exactly one lamp per direction lit.
REQ-025 NS lamps: green in NS_G, amber in NS_A, red in all other phases.
REQ-026 EW lamps: green in EW_G, amber in EW_A, red in all other phases.
REQ-027 walk_o=1 only in WALK.
REQ-028 Every output changes on the same edge as the state change; there is no extra latency.
REQ-029 Parameters SHALL be in the range 1..31, and MIN_GREEN_T<=GREEN_T; violations are an elaboration-time error.

Reset
REQ-030 rst_i=1 overrides tick_i and ped_req_i.
REQ-031 Reset values: state NS_G, time_o=GREEN_T-1, ped_pending=0, next-direction=EW.
REQ-032 Reset output values: ns_green_o=1, ew_red_o=1, all other lamps 0, walk_o=0, ped_wait_o=0.
REQ-033 Reset asserted mid-phase, including WALK, takes effect on that edge and drops any pending request.

Structure
REQ-034 Package intersection_pkg holds: the phase enum typedef (3-bit), default duration constants, and the 5-bit time width constant.
REQ-035 One sub-module, phase_timer: load value, tick enable, 5-bit down-counter, done flag (count=0 and tick).

Verification
REQ-036 Reset, then tick_i=1 constant with no requests -> states 0,1,2,3,4,5 last 6,2,1,6,2,1 cycles, then repeat; walk_o stays 0.
REQ-037 Single-cycle ped_req_i pulse on the first cycle after reset -> ped_wait_o=1 next edge; NS_G lasts 3 cycles, then NS_A 2, CLR_A 1, WALK 4 with ped_wait_o=0 and walk_o=1, then EW_G for 6 cycles.
REQ-038 ped_req_i held high throughout WALK -> ped_wait_o stays 0 in WALK; it sets on the first cycle of EW_G, which then lasts 3 cycles.
REQ-039 tick_i=1 only every 4th cycle -> every phase lasts 4x its tick count in clocks; state_o and time_o are stable between ticks.
REQ-040 rst_i pulsed during WALK at time_o=2 -> next edge gives state_o=0, time_o=5, walk_o=0, ns_green_o=1.
REQ-041 Request during EW_G after 4 elapsed ticks (past the minimum) -> EW_G exits on the next tick; CLR_B is followed by WALK, then NS_G.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection controller.
//   phase_e      : 3-bit phase encoding (code 7 unused / illegal)
//   lamps_t      : packed lamp set {ns g/a/r, ew g/a/r, walk}
//   phase_lamps(): Moore lamp decode for a phase
package intersection_pkg;

    localparam int TIME_W          = 5;
    localparam int GREEN_T_DEF     = 6;
    localparam int AMBER_T_DEF     = 2;
    localparam int CLEAR_T_DEF     = 1;
    localparam int WALK_T_DEF      = 4;
    localparam int MIN_GREEN_T_DEF = 3;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_A  = 3'd1,
        CLR_A = 3'd2,
        EW_G  = 3'd3,
        EW_A  = 3'd4,
        CLR_B = 3'd5,
        WALK  = 3'd6
    } phase_e;

    typedef struct packed {
        logic ns_g;
        logic ns_a;
        logic ns_r;
        logic ew_g;
        logic ew_a;
        logic ew_r;
        logic walk;
    } lamps_t;

    // Exactly one lamp per direction; anything not green/amber is red,
    // which also makes the illegal code fail safe (all red).
    function automatic lamps_t phase_lamps(input phase_e p);
        lamps_t l;
        l.ns_g = (p == NS_G);
        l.ns_a = (p == NS_A);
        l.ns_r = !(p == NS_G || p == NS_A);
        l.ew_g = (p == EW_G);
        l.ew_a = (p == EW_A);
        l.ew_r = !(p == EW_G || p == EW_A);
        l.walk = (p == WALK);
        return l;
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// phase_timer: per-phase down-counter.
//   clk_i, rst_i : clock, synchronous active-high reset (loads RST_VAL)
//   tick         : timebase enable
//   load         : load load_val (phase entry), has priority over tick
//   count        : ticks remaining minus one
//   done         : count == 0 on a tick cycle
module phase_timer
    import intersection_pkg::*;
#(
    parameter int              W       = TIME_W,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - 1'b1;
    end

    assign done = tick && (count == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-way traffic light with pedestrian walk phase.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   tick_i            : timebase enable, timers advance only when high
//   ped_req_i         : pedestrian button (level or pulse)
//   ns_*_o, ew_*_o    : lamps, one lit per direction
//   walk_o            : walk lamp
//   ped_wait_o        : request latched and not yet served
//   state_o, time_o   : current phase and ticks remaining minus one
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int GREEN_T     = GREEN_T_DEF,
    parameter int AMBER_T     = AMBER_T_DEF,
    parameter int CLEAR_T     = CLEAR_T_DEF,
    parameter int WALK_T      = WALK_T_DEF,
    parameter int MIN_GREEN_T = MIN_GREEN_T_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              ped_req_i,
    output logic              ns_green_o,
    output logic              ns_amber_o,
    output logic              ns_red_o,
    output logic              ew_green_o,
    output logic              ew_amber_o,
    output logic              ew_red_o,
    output logic              walk_o,
    output logic              ped_wait_o,
    output logic [2:0]        state_o,
    output logic [TIME_W-1:0] time_o
);

    if (GREEN_T < 1 || GREEN_T > 31 || AMBER_T < 1 || AMBER_T > 31 ||
        CLEAR_T < 1 || CLEAR_T > 31 || WALK_T < 1 || WALK_T > 31 ||
        MIN_GREEN_T < 1 || MIN_GREEN_T > 31 || MIN_GREEN_T > GREEN_T) begin : g_bad_param
        $error("intersection_ctrl: durations must be 1..31 and MIN_GREEN_T <= GREEN_T");
    end

    localparam logic [TIME_W-1:0] GREEN_LD  = TIME_W'(GREEN_T - 1);
    localparam logic [TIME_W-1:0] AMBER_LD  = TIME_W'(AMBER_T - 1);
    localparam logic [TIME_W-1:0] CLEAR_LD  = TIME_W'(CLEAR_T - 1);
    localparam logic [TIME_W-1:0] WALK_LD   = TIME_W'(WALK_T - 1);
    // Green may be cut short once time_o has fallen to this value.
    localparam logic [TIME_W-1:0] EARLY_MAX = TIME_W'(GREEN_T - MIN_GREEN_T);

    phase_e            state, nxt;
    logic              ped_pending;
    logic              next_ew;     // WALK returns to EW_G when set, NS_G otherwise
    lamps_t            lamps;
    logic [TIME_W-1:0] cnt, load_val;
    logic              done, load, cut_green;

    function automatic logic [TIME_W-1:0] load_of(input phase_e p);
        case (p)
            NS_A, EW_A:   return AMBER_LD;
            CLR_A, CLR_B: return CLEAR_LD;
            WALK:         return WALK_LD;
            default:      return GREEN_LD;
        endcase
    endfunction

    phase_timer #(.W(TIME_W), .RST_VAL(GREEN_LD)) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .tick     (tick_i),
        .load     (load),
        .load_val (load_val),
        .count    (cnt),
        .done     (done)
    );

    assign cut_green = ped_pending && tick_i && (cnt <= EARLY_MAX);

    always_comb begin
        nxt = state;
        case (state)
            NS_G:    if (done || cut_green) nxt = NS_A;
            NS_A:    if (done) nxt = CLR_A;
            CLR_A:   if (done) nxt = ped_pending ? WALK : EW_G;
            EW_G:    if (done || cut_green) nxt = EW_A;
            EW_A:    if (done) nxt = CLR_B;
            CLR_B:   if (done) nxt = ped_pending ? WALK : NS_G;
            WALK:    if (done) nxt = next_ew ? EW_G : NS_G;
            default: nxt = NS_G;  // illegal code recovers immediately
        endcase
    end

    // Every phase change reloads the timer, so the timer and state move together.
    assign load     = (nxt != state);
    assign load_val = load_of(nxt);

    // Lamps are registered from the next state so they switch on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= NS_G;
            ped_pending <= 1'b0;
            next_ew     <= 1'b1;
            lamps       <= phase_lamps(NS_G);
        end else begin
            state <= nxt;
            lamps <= phase_lamps(nxt);
            if (nxt == WALK && state != WALK) begin
                ped_pending <= 1'b0;
                next_ew     <= (state == CLR_A);
            end else if (ped_req_i && state != WALK) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign ns_green_o = lamps.ns_g;
    assign ns_amber_o = lamps.ns_a;
    assign ns_red_o   = lamps.ns_r;
    assign ew_green_o = lamps.ew_g;
    assign ew_amber_o = lamps.ew_a;
    assign ew_red_o   = lamps.ew_r;
    assign walk_o     = lamps.walk;
    assign ped_wait_o = ped_pending;
    assign state_o    = state;
    assign time_o     = cnt;

endmodule
